// File: rtl/seq_divider.sv
// Sequential radix-2 restoring divider: 2W-bit dividend / W-bit divisor, one quotient bit per cycle.
// Define SEQ_DIVIDER_SIGNED_EN for two's-complement operands; the default build is purely unsigned.
module seq_divider #(
    parameter int W_DIVISOR = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [2*W_DIVISOR-1:0] dividend,
    input  logic [W_DIVISOR-1:0]   divisor,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [W_DIVISOR-1:0]   quotient,
    output logic [W_DIVISOR-1:0]   remainder,
    output logic                   ovf,
    output logic                   dbz
);

    localparam int W  = W_DIVISOR;
    localparam int WD = 2 * W_DIVISOR;
    localparam int CW = $clog2(WD);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t        state_q, state_d;
    logic [WD-1:0] q_q, q_d;
    logic [W:0]    rem_q, rem_d;
    logic [W-1:0]  dvsr_q, dvsr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  quot_q, quot_d;
    logic [W-1:0]  rmd_q, rmd_d;
    logic          ovf_q, ovf_d;
    logic          dbz_q, dbz_d;
`ifdef SEQ_DIVIDER_SIGNED_EN
    logic          qneg_q, qneg_d;
    logic          rneg_q, rneg_d;
    localparam logic [W-1:0] MAX_POS = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};
`endif

    logic          accept;
    logic [W:0]    rem_shift;
    logic          trial_ge;

    assign accept    = in_valid && in_ready;
    assign rem_shift = {rem_q[W-1:0], q_q[WD-1]};
    assign trial_ge  = rem_shift >= {1'b0, dvsr_q};

    // NOTE: state and datapath flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = (divisor == '0) ? FIX : CALC;
            CALC: if (cnt_q == '0) state_d = FIX;
            FIX:  state_d = DONE;
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // in_ready is gated by rst_n so it reads 0 while reset is held and 1 as soon as it is released.
    always_comb begin
        in_ready  = rst_n && (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    // NOTE: every _d gets a hold default first so no path through the case can infer a latch.
    always_comb begin
        q_d    = q_q;
        rem_d  = rem_q;
        dvsr_d = dvsr_q;
        cnt_d  = cnt_q;
        quot_d = quot_q;
        rmd_d  = rmd_q;
        ovf_d  = ovf_q;
        dbz_d  = dbz_q;
`ifdef SEQ_DIVIDER_SIGNED_EN
        qneg_d = qneg_q;
        rneg_d = rneg_q;
`endif
        case (state_q)
            IDLE: if (accept) begin
                rem_d = '0;
                cnt_d = CW'(WD - 1);
`ifdef SEQ_DIVIDER_SIGNED_EN
                // 2^(WD-1) is representable as an unsigned WD-bit magnitude, so -min needs no extra bit.
                dvsr_d = divisor[W-1] ? -divisor : divisor;
                q_d    = (divisor == '0 || !dividend[WD-1]) ? dividend : -dividend;
                qneg_d = dividend[WD-1] ^ divisor[W-1];
                rneg_d = dividend[WD-1];
`else
                dvsr_d = divisor;
                q_d    = dividend;
`endif
            end
            CALC: begin
                q_d   = {q_q[WD-2:0], trial_ge};
                rem_d = trial_ge ? (rem_shift - {1'b0, dvsr_q}) : rem_shift;
                cnt_d = cnt_q - 1'b1;
            end
            FIX: begin
                if (dvsr_q == '0) begin
                    // Divide by zero: q_q still holds the raw dividend.
                    dbz_d = 1'b1;
                    ovf_d = 1'b0;
                    rmd_d = q_q[W-1:0];
`ifdef SEQ_DIVIDER_SIGNED_EN
                    quot_d = q_q[WD-1] ? MIN_NEG : MAX_POS;
`else
                    quot_d = '1;
`endif
                end else begin
                    dbz_d = 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
                    if (qneg_q) begin
                        ovf_d  = q_q > {{W{1'b0}}, MIN_NEG};
                        quot_d = ovf_d ? MIN_NEG : -q_q[W-1:0];
                    end else begin
                        ovf_d  = q_q > {{W{1'b0}}, MAX_POS};
                        quot_d = ovf_d ? MAX_POS : q_q[W-1:0];
                    end
                    rmd_d = rneg_q ? -rem_q[W-1:0] : rem_q[W-1:0];
`else
                    ovf_d  = |q_q[WD-1:W];
                    quot_d = ovf_d ? '1 : q_q[W-1:0];
                    rmd_d  = rem_q[W-1:0];
`endif
                end
            end
            default: ;
        endcase
    end

    // NOTE: the whole datapath is reset so an aborted operation never leaves a partial result visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q    <= '0;
            rem_q  <= '0;
            dvsr_q <= '0;
            cnt_q  <= '0;
            quot_q <= '0;
            rmd_q  <= '0;
            ovf_q  <= 1'b0;
            dbz_q  <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
`endif
        end else begin
            q_q    <= q_d;
            rem_q  <= rem_d;
            dvsr_q <= dvsr_d;
            cnt_q  <= cnt_d;
            quot_q <= quot_d;
            rmd_q  <= rmd_d;
            ovf_q  <= ovf_d;
            dbz_q  <= dbz_d;
`ifdef SEQ_DIVIDER_SIGNED_EN
            qneg_q <= qneg_d;
            rneg_q <= rneg_d;
`endif
        end
    end

    assign quotient  = quot_q;
    assign remainder = rmd_q;
    assign ovf       = ovf_q;
    assign dbz       = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed vector table, handshake/reset sequences, random ops vs model.
// Builds for either configuration; SEQ_DIVIDER_SIGNED_EN selects the signed expectations.
module tb_seq_divider;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] dividend;
    logic [15:0] divisor;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        ovf;
    logic        dbz;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] n;
        logic [15:0] d;
        logic [15:0] q;
        logic [15:0] r;
        logic        o;
        logic        z;
    } vec_t;

    vec_t vecs[$];

    seq_divider #(.W_DIVISOR(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .ovf       (ovf),
        .dbz       (dbz)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain integer division on 64-bit values, then the saturation rules.
    function automatic void model(input logic [31:0] n, input logic [15:0] d,
                                  output logic [15:0] q, output logic [15:0] r,
                                  output logic o, output logic z);
`ifdef SEQ_DIVIDER_SIGNED_EN
        longint sn = longint'($signed(n));
        longint sd = longint'($signed(d));
        longint tq;
        longint tr;
        if (sd == 0) begin
            z = 1'b1; o = 1'b0;
            q = (sn < 0) ? 16'h8000 : 16'h7FFF;
            r = n[15:0];
        end else begin
            tq = sn / sd;
            tr = sn % sd;
            z = 1'b0;
            o = (tq > 32767) || (tq < -32768);
            q = (tq > 32767) ? 16'h7FFF : (tq < -32768) ? 16'h8000 : 16'(tq);
            r = 16'(tr);
        end
`else
        longint un = longint'(n);
        longint ud = longint'(d);
        longint tq;
        if (ud == 0) begin
            z = 1'b1; o = 1'b0; q = 16'hFFFF; r = n[15:0];
        end else begin
            tq = un / ud;
            z = 1'b0;
            o = tq > 65535;
            q = o ? 16'hFFFF : 16'(tq);
            r = 16'(un % ud);
        end
`endif
    endfunction

    // One full transaction: accept, latency, result, optional back-pressure, handshake.
    task automatic do_op(input string name, input logic [31:0] n, input logic [15:0] d,
                         input logic [15:0] eq, input logic [15:0] er,
                         input logic eo, input logic ez, input int hold);
        int lat;
        @(negedge clk);
        check({name, " in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1; dividend = n; divisor = d;
        @(posedge clk); #1;
        in_valid = 1'b0; dividend = $urandom; divisor = 16'($urandom);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!out_valid && lat < 100);
        check({name, " latency"}, 32'(lat), (d == 16'd0) ? 32'd1 : 32'd33);
        check({name, " quotient"}, 32'(quotient), 32'(eq));
        check({name, " remainder"}, 32'(remainder), 32'(er));
        check({name, " ovf/dbz"}, {30'd0, ovf, dbz}, {30'd0, eo, ez});
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            in_valid = 1'b1; dividend = $urandom; divisor = 16'($urandom);
            check({name, " hold state"}, {30'd0, out_valid, in_ready}, 32'b10);
            check({name, " hold result"}, {quotient, remainder}, {eq, er});
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({name, " after hs"}, {30'd0, out_valid, in_ready}, 32'b01);
        check({name, " held after hs"}, {quotient, remainder}, {eq, er});
    endtask

    initial begin
        logic [31:0] rn;
        logic [15:0] rd;
        logic [15:0] mq;
        logic [15:0] mr;
        logic        mo;
        logic        mz;

`ifdef SEQ_DIVIDER_SIGNED_EN
        vecs.push_back('{32'hFFFF_FFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 1'b0, 1'b0});
        vecs.push_back('{32'h8000_0000, 16'hFFFF, 16'h7FFF, 16'h0000, 1'b1, 1'b0});
        vecs.push_back('{32'd1000,      16'd7,    16'd142,  16'd6,    1'b0, 1'b0});
        vecs.push_back('{32'h0000_0007, 16'hFFFE, 16'hFFFD, 16'h0001, 1'b0, 1'b0});
        vecs.push_back('{32'h1234_5678, 16'h0000, 16'h7FFF, 16'h5678, 1'b0, 1'b1});
        vecs.push_back('{32'h8000_1234, 16'h0000, 16'h8000, 16'h1234, 1'b0, 1'b1});
        vecs.push_back('{32'hFFFF_0000, 16'h0002, 16'h8000, 16'h0000, 1'b0, 1'b0});
        vecs.push_back('{32'hFFFE_FFFE, 16'h0002, 16'h8000, 16'h0000, 1'b1, 1'b0});
        vecs.push_back('{32'h0001_0000, 16'h0002, 16'h7FFF, 16'h0000, 1'b1, 1'b0});
        vecs.push_back('{32'h8000_0000, 16'h8000, 16'h7FFF, 16'h0000, 1'b1, 1'b0});
        vecs.push_back('{32'hFFFF_FF9C, 16'h0007, 16'hFFF2, 16'hFFFE, 1'b0, 1'b0});
`else
        vecs.push_back('{32'd1000,      16'd7,    16'd142,  16'd6,    1'b0, 1'b0});
        vecs.push_back('{32'h0001_0000, 16'h0001, 16'hFFFF, 16'h0000, 1'b1, 1'b0});
        vecs.push_back('{32'hFFFE_0001, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b0});
        vecs.push_back('{32'h1234_5678, 16'h0000, 16'hFFFF, 16'h5678, 1'b0, 1'b1});
        vecs.push_back('{32'hFFFF_FFFF, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b1, 1'b0});
        vecs.push_back('{32'h0000_0000, 16'h0005, 16'h0000, 16'h0000, 1'b0, 1'b0});
        vecs.push_back('{32'hFFFF_FFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b1, 1'b0});
        vecs.push_back('{32'd12345,     16'd12346, 16'h0000, 16'd12345, 1'b0, 1'b0});
        vecs.push_back('{32'h0000_FFFF, 16'h0100, 16'h00FF, 16'h00FF, 1'b0, 1'b0});
`endif

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        dividend = '0; divisor = '0;
        #12;
        check("reset in_ready", 32'(in_ready), 32'd0);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset result", {quotient, remainder}, 32'd0);
        check("reset flags", {30'd0, ovf, dbz}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("release in_ready", 32'(in_ready), 32'd1);

        foreach (vecs[i])
            do_op($sformatf("vec%0d", i), vecs[i].n, vecs[i].d, vecs[i].q, vecs[i].r,
                  vecs[i].o, vecs[i].z, (i == 0) ? 10 : 0);

        // Reset abort in the middle of CALC.
        @(negedge clk);
        in_valid = 1'b1; dividend = 32'd1000; divisor = 16'd7;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (15) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort in_ready", 32'(in_ready), 32'd0);
        check("abort out_valid", 32'(out_valid), 32'd0);
        check("abort result", {quotient, remainder}, 32'd0);
        check("abort flags", {30'd0, ovf, dbz}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op("post-reset 100/10", 32'd100, 16'd10, 16'd10, 16'd0, 1'b0, 1'b0, 0);

        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(0, 3))
                0:       rd = 16'd0;
                1:       rd = 16'($urandom_range(1, 15));
                default: rd = 16'($urandom);
            endcase
            rn = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 3) == 0) rn = $urandom;
            model(rn, rd, mq, mr, mo, mz);
            do_op($sformatf("rnd%0d", k), rn, rd, mq, mr, mo, mz, $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
